// File: rtl/adc_pattern_pkg.sv
// Shared definitions for the ADC test-pattern generator: mode and register-select
// encodings plus the maximal-length LFSR tap table indexed by sample width.
package adc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  localparam logic [1:0] SEL_MODE   = 2'd0;
  localparam logic [1:0] SEL_STEP   = 2'd1;
  localparam logic [1:0] SEL_LOAD   = 2'd2;
  localparam logic [1:0] SEL_PERIOD = 2'd3;

  // Fibonacci tap mask, bit n-1 set for tap n (maximal-length polynomials)
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/adc_pattern_gen_if.sv
// Config/sample bus of the ADC pattern generator; master drives config and
// enables, slave returns the tri-stated per-channel samples and overflow flags.
interface adc_pattern_gen_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 14
);
  logic                     cfg_wr;
  logic [$clog2(NCH)+1:0]   cfg_addr;
  logic [15:0]              cfg_data;
  logic [NCH-1:0]           adc_on;
  logic [NCH-1:0]           adc_oe;
  logic [NCH*WIDTH-1:0]     adc_data;
  logic [NCH-1:0]           adc_ovf;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, adc_on, adc_oe,
    input  adc_data, adc_ovf
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, adc_on, adc_oe,
    output adc_data, adc_ovf
  );
endinterface

// File: rtl/adc_pattern_chan.sv
// One pattern channel: MODE/STEP/LOAD/PERIOD registers and the sample accumulator.
// LFSR mode is built only when ADC_PATTERN_LFSR_EN is defined; otherwise it holds.
module adc_pattern_chan
  import adc_pattern_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       sel_i,
  input  logic [15:0]      data_i,
  input  logic             on_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [15:0]      period_q, period_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_s;
  logic             wrap_s;
  logic [15:0]      last_s;

  // Sign-extended add exposes overflow as a mismatch of the top two bits
  always_comb begin
    sum_s  = {acc_q[WIDTH-1], acc_q} + {step_q[WIDTH-1], step_q};
    wrap_s = (sum_s[WIDTH] != sum_s[WIDTH-1]);
    last_s = (period_q == 16'd0) ? 16'd0 : (period_q - 16'd1);
  end

`ifdef ADC_PATTERN_LFSR_EN
  localparam logic [15:0] TAPS16 = lfsr_taps(WIDTH);
  logic [WIDTH-1:0] lfsr_next_s;

  // Zero state would lock up the shift register, so escape to 1
  always_comb begin
    if (acc_q == {WIDTH{1'b0}}) begin
      lfsr_next_s = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      lfsr_next_s = {acc_q[WIDTH-2:0], ^(acc_q & TAPS16[WIDTH-1:0])};
    end
  end
`endif

  // Pattern update first, then config writes override it (LOAD beats the update)
  always_comb begin
    mode_d   = mode_q;
    step_d   = step_q;
    load_d   = load_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    if (on_i) begin
      case (mode_q)
        MODE_RAMP: begin
          ovf_d = wrap_s;
          if (wrap_s && (SAT != 0)) begin
            acc_d = sum_s[WIDTH] ? SMIN : SMAX;
          end else begin
            acc_d = sum_s[WIDTH-1:0];
          end
        end
        MODE_SQUARE: begin
          ovf_d = 1'b0;
          if (cnt_q >= last_s) begin
            cnt_d = 16'd0;
            acc_d = (acc_q == load_q) ? ({WIDTH{1'b0}} - load_q) : load_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
`ifdef ADC_PATTERN_LFSR_EN
        MODE_LFSR: begin
          ovf_d = 1'b0;
          acc_d = lfsr_next_s;
        end
`endif
        default: begin
          ovf_d = 1'b0;
        end
      endcase
    end else begin
      acc_d = acc_q;
    end

    if (wr_en_i) begin
      case (sel_i)
        SEL_MODE: begin
          mode_d = mode_e'(data_i[1:0]);
          cnt_d  = 16'd0;
        end
        SEL_STEP: begin
          step_d = data_i[WIDTH-1:0];
        end
        SEL_LOAD: begin
          load_d = data_i[WIDTH-1:0];
          acc_d  = data_i[WIDTH-1:0];
          cnt_d  = 16'd0;
          ovf_d  = 1'b0;
        end
        SEL_PERIOD: begin
          period_d = data_i;
        end
        default: begin
          period_d = period_q;
        end
      endcase
    end else begin
      mode_d = mode_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_RAMP;
      step_q   <= {WIDTH{1'b0}};
      load_q   <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      period_q <= 16'd0;
      cnt_q    <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      step_q   <= step_d;
      load_q   <= load_d;
      acc_q    <= acc_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/adc_pattern_gen.sv
// ADC test-pattern generator top: reset synchroniser, config address decode and
// NCH pattern channels with per-channel tri-state outputs. Option: ADC_PATTERN_LFSR_EN.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 14,
  parameter int SAT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_pattern_gen_if.slave  bus
);

  localparam int AW = $clog2(NCH) + 2;

  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  logic [7:0] ch_idx_s;

  // Asynchronous assert, release two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  if (NCH > 1) begin : g_idx
    assign ch_idx_s = 8'(bus.cfg_addr[AW-1:2]);
  end else begin : g_idx_single
    assign ch_idx_s = 8'd0;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] acc_s;
    logic             ovf_s;

    // Indices >= NCH match no channel, so those writes fall away
    adc_pattern_chan #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .wr_en_i (bus.cfg_wr && (ch_idx_s == 8'(c))),
      .sel_i   (bus.cfg_addr[1:0]),
      .data_i  (bus.cfg_data),
      .on_i    (bus.adc_on[c]),
      .acc_o   (acc_s),
      .ovf_o   (ovf_s)
    );

    assign bus.adc_data[c*WIDTH +: WIDTH] = bus.adc_oe[c] ? acc_s : {WIDTH{1'bz}};
    assign bus.adc_ovf[c]                 = bus.adc_oe[c] ? ovf_s : 1'bz;
  end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Self-checking bench: 2-channel wrapping DUT against a signed-integer reference
// model, plus a 1-channel saturating DUT for clamp behaviour.
module tb_adc_pattern_gen;

  localparam int W    = 14;
  localparam int MOD  = 16384;
  localparam int MAXV = 8191;
  localparam int MINV = -8192;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  adc_pattern_gen_if #(.NCH(2), .WIDTH(W)) bus0 ();
  adc_pattern_gen_if #(.NCH(1), .WIDTH(W)) bus1 ();

  adc_pattern_gen #(.NCH(2), .WIDTH(W), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  adc_pattern_gen #(.NCH(1), .WIDTH(W), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_acc  [2];
  int   m_step [2];
  int   m_mode [2];
  logic m_ovf  [2];
  bit   chk    [2];

  function automatic int sx(input logic [13:0] v);
    return v[13] ? (int'(v) - MOD) : int'(v);
  endfunction

  function automatic logic [13:0] enc(input int v);
    logic [13:0] r;
    r = v[13:0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] avoid);
    n_cmp++;
    assert (obs !== avoid) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected anything but %0h", tag, obs, avoid);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_step[c] = 0; m_mode[c] = 0; m_ovf[c] = 1'b0;
    end
  endtask

  // Reference behaviour for one clock edge of dut0, from the inputs now applied
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      int s;
      if (bus0.adc_on[c]) begin
        if (m_mode[c] == 0) begin
          s = m_acc[c] + m_step[c];
          m_ovf[c] = (s > MAXV) || (s < MINV);
          if (s > MAXV) s -= MOD;
          if (s < MINV) s += MOD;
          m_acc[c] = s;
        end else if (m_mode[c] == 1) begin
          m_ovf[c] = 1'b0;
        end else if (m_mode[c] == 2) begin
`ifndef ADC_PATTERN_LFSR_EN
          m_ovf[c] = 1'b0;
`endif
        end
      end
      if (bus0.cfg_wr && (int'(bus0.cfg_addr[2]) == c)) begin
        case (bus0.cfg_addr[1:0])
          2'd0: m_mode[c] = int'(bus0.cfg_data[1:0]);
          2'd1: m_step[c] = sx(bus0.cfg_data[13:0]);
          2'd2: begin m_acc[c] = sx(bus0.cfg_data[13:0]); m_ovf[c] = 1'b0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (chk[c] && bus0.adc_oe[c]) begin
        check($sformatf("model_data_ch%0d", c), 32'(bus0.adc_data[c*W +: W]), 32'(enc(m_acc[c])));
        check($sformatf("model_ovf_ch%0d", c), 32'(bus0.adc_ovf[c]), 32'(m_ovf[c]));
      end
    end
  endtask

  task automatic wr0(input int ch, input int sel, input logic [15:0] d);
    bus0.cfg_wr   = 1'b1;
    bus0.cfg_addr = {ch[0], sel[1:0]};
    bus0.cfg_data = d;
    tick();
    bus0.cfg_wr   = 1'b0;
  endtask

  task automatic wr1(input int sel, input logic [15:0] d);
    bus1.cfg_wr   = 1'b1;
    bus1.cfg_addr = sel[1:0];
    bus1.cfg_data = d;
    tick();
    bus1.cfg_wr   = 1'b0;
  endtask

  initial begin
    logic [13:0] first;
    logic [13:0] v;
    rst_n = 1'b0;
    bus0.cfg_wr = 1'b0; bus0.cfg_addr = 3'd0; bus0.cfg_data = 16'd0;
    bus0.adc_on = 2'b00; bus0.adc_oe = 2'b11;
    bus1.cfg_wr = 1'b0; bus1.cfg_addr = 2'd0; bus1.cfg_data = 16'd0;
    bus1.adc_on = 1'b0;  bus1.adc_oe = 1'b1;
    model_reset();
    chk[0] = 1'b1; chk[1] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_data0", 32'(bus0.adc_data), 32'd0);
    check("reset_ovf0", 32'(bus0.adc_ovf), 32'd0);
    check("reset_data1", 32'(bus1.adc_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Two channels with opposite-sign steps
    wr0(0, 1, 16'd3);
    wr0(1, 1, 16'h3FF9);
    bus0.adc_on = 2'b11;
    repeat (4) tick();
    check("ramp4_ch0", 32'(bus0.adc_data[13:0]), 32'd12);
    check("ramp4_ch1", 32'(bus0.adc_data[27:14]), 32'd16356);

    // Random enables and config writes, ramp/hold modes
    for (int i = 0; i < 300; i++) begin
      bus0.adc_on = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int sel;
        sel = $urandom_range(0, 2);
        bus0.cfg_wr   = 1'b1;
        bus0.cfg_addr = {1'($urandom), sel[1:0]};
        bus0.cfg_data = (sel == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom);
      end
      tick();
      bus0.cfg_wr = 1'b0;
    end

    // Wrap by one step past the positive limit
    bus0.adc_on = 2'b00;
    wr0(0, 0, 16'd0);
    wr0(0, 1, 16'd3);
    wr0(0, 2, 16'd8190);
    bus0.adc_on = 2'b01;
    tick();
    check("wrap_val", 32'(bus0.adc_data[13:0]), 32'd8193);
    check("wrap_ovf", 32'(bus0.adc_ovf[0]), 32'd1);
    tick();
    check("wrap_ovf_clear", 32'(bus0.adc_ovf[0]), 32'd0);
    bus0.adc_on = 2'b00;

    // Saturating instance, both limits
    wr1(1, 16'd3);
    wr1(2, 16'd8190);
    bus1.adc_on = 1'b1;
    tick();
    check("sat_hi_val1", 32'(bus1.adc_data), 32'd8191);
    check("sat_hi_ovf1", 32'(bus1.adc_ovf), 32'd1);
    tick();
    check("sat_hi_val2", 32'(bus1.adc_data), 32'd8191);
    check("sat_hi_ovf2", 32'(bus1.adc_ovf), 32'd1);
    bus1.adc_on = 1'b0;
    wr1(1, 16'hFFFD);
    wr1(2, 16'h2002);
    bus1.adc_on = 1'b1;
    tick();
    check("sat_lo_val", 32'(bus1.adc_data), 32'd8192);
    check("sat_lo_ovf", 32'(bus1.adc_ovf), 32'd1);
    bus1.adc_on = 1'b0;

    // Square wave on ch1: sample i after the load is +L for even i/P, else -L
    chk[1] = 1'b0;
    wr0(1, 0, 16'd3);
    wr0(1, 3, 16'd4);
    wr0(1, 2, 16'd100);
    check("sq_load", 32'(bus0.adc_data[27:14]), 32'd100);
    bus0.adc_on = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("sq_p4_k%0d", k), 32'(bus0.adc_data[27:14]),
            32'(enc(((k / 4) % 2 == 0) ? 100 : -100)));
    end
    bus0.adc_on = 2'b00;
    wr0(1, 3, 16'd0);
    wr0(1, 2, 16'd5);
    bus0.adc_on = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("sq_p0_k%0d", k), 32'(bus0.adc_data[27:14]),
            32'(enc((k % 2 == 0) ? 5 : -5)));
    end
    bus0.adc_on = 2'b00;
    wr0(1, 0, 16'd0);
    wr0(1, 2, 16'd0);
    chk[1] = 1'b1;

    // Output enable low: lane released while the ramp keeps running
    wr0(0, 1, 16'd3);
    wr0(0, 2, 16'd1);
    bus0.adc_oe = 2'b10;
    bus0.adc_on = 2'b11;
    repeat (3) begin
      tick();
      check_ne("oe_off_data", 32'(bus0.adc_data[13:0]), 32'(enc(m_acc[0])));
    end
    bus0.adc_oe = 2'b11;
    tick();
    check("oe_restore", 32'(bus0.adc_data[13:0]), 32'd13);

    // LOAD in the same cycle as an enabled ramp update
    bus0.adc_on = 2'b01;
    wr0(0, 2, 16'd1234);
    check("load_wins", 32'(bus0.adc_data[13:0]), 32'd1234);
    tick();

    // Asynchronous reset mid-stream with a write pending
    bus0.adc_on = 2'b11;
    repeat (2) tick();
    rst_n = 1'b0;
    bus0.cfg_wr = 1'b1; bus0.cfg_addr = 3'b010; bus0.cfg_data = 16'd999;
    #1;
    check("rst_async_data0", 32'(bus0.adc_data), 32'd0);
    check("rst_async_ovf0", 32'(bus0.adc_ovf), 32'd0);
    check("rst_async_data1", 32'(bus1.adc_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus0.cfg_wr = 1'b0;
    bus0.adc_on = 2'b00;
    model_reset();
    repeat (3) tick();

`ifdef ADC_PATTERN_LFSR_EN
    chk[0] = 1'b0;
    wr0(0, 0, 16'd2);
    wr0(0, 2, 16'd0);
    bus0.adc_on = 2'b01;
    tick();
    first = bus0.adc_data[13:0];
    check("lfsr_first", 32'(first), 32'd1);
    for (int k = 1; k <= 16383; k++) begin
      tick();
      v = bus0.adc_data[13:0];
      check_ne("lfsr_zero", 32'(v), 32'd0);
      if (k < 16383) check_ne("lfsr_early_repeat", 32'(v), 32'(first));
      else           check("lfsr_period", 32'(v), 32'(first));
    end
    bus0.adc_on = 2'b00;
    wr0(0, 0, 16'd0);
    wr0(0, 2, 16'd0);
    chk[0] = 1'b1;
`else
    first = 14'd77;
    wr0(0, 1, 16'd5);
    wr0(0, 2, 16'(first));
    wr0(0, 0, 16'd2);
    bus0.adc_on = 2'b01;
    repeat (5) tick();
    v = bus0.adc_data[13:0];
    check("mode2_hold", 32'(v), 32'(first));
    bus0.adc_on = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_pattern_gen.md
ADC_PATTERN_GEN -- requirements
Module: adc_pattern_gen

Interface
REQ-001 SHALL have parameter NCH, 2, number of ADC channels (1..8).
REQ-002 SHALL have parameter WIDTH, 14, sample width in bits (8..16).
REQ-003 SHALL have parameter SAT, 0, 1 = ramp saturates at limits, 0 = ramp wraps.
REQ-004 SHALL have port clk  in  1  sample clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_wr  in  1  config write strobe, one write per asserted cycle.
REQ-007 SHALL have port cfg_addr  in  $clog2(NCH)+2  channel index in the upper bits, register select in the low 2 bits.
REQ-008 SHALL have port cfg_data  in  16  write data.
REQ-009 SHALL have port adc_on  in  NCH  per-channel run enable.
REQ-010 SHALL have port adc_oe  in  NCH  per-channel output enable.
REQ-011 SHALL have port adc_data  out  NCH*WIDTH  samples, channel 0 in the LSBs, driven Z per channel when its oe bit is 0.
REQ-012 SHALL have port adc_ovf  out  NCH  per-channel overflow flag, driven Z when its oe bit is 0.

Function
REQ-013 SHALL hold, per channel, four registers: sel 0 MODE[1:0], sel 1 STEP (signed, WIDTH bits), sel 2 LOAD (WIDTH bits), sel 3 PERIOD (16 bits).
REQ-014 SHALL use MODE encodings 0 RAMP, 1 HOLD, 2 LFSR, 3 SQUARE.
REQ-015 SHALL update a channel's accumulator acc only in cycles where its adc_on bit is 1; acc SHALL hold otherwise.
REQ-016 In RAMP mode, each enabled cycle SHALL compute acc <= acc + STEP in two's complement.
REQ-017 In RAMP mode with SAT=0, the result SHALL wrap, and ovf SHALL be 1 for exactly the cycle whose result wrapped.
REQ-018 In RAMP mode with SAT=1, the result SHALL clamp to the max/min signed value, and ovf SHALL stay 1 while clamped.
REQ-019 In HOLD mode, acc SHALL be unchanged and ovf SHALL be 0.
REQ-020 In LFSR mode, acc SHALL advance one step per enabled cycle using the maximal-length Fibonacci LFSR of WIDTH bits, and ovf SHALL be 0.
REQ-021 In SQUARE mode, a 16-bit counter SHALL count enabled cycles.
REQ-022 In SQUARE mode, acc SHALL toggle between +LOAD and -LOAD when the counter reaches PERIOD-1, and the counter SHALL then return to 0.
REQ-023 In SQUARE mode, PERIOD=0 SHALL be treated as 1.
REQ-024 A write to LOAD SHALL set acc to cfg_data[WIDTH-1:0] on the next edge, SHALL clear the square counter and ovf, and SHALL win over a same-cycle mode update.
REQ-025 A write to MODE SHALL take effect from the next edge and SHALL clear the square counter; acc SHALL be retained.
REQ-026 In LFSR mode, an all-zero acc SHALL be replaced by 1 on its next enabled update (lock-up escape).
REQ-027 Writes to a channel index >= NCH SHALL be ignored.
REQ-028 adc_data SHALL equal the registered acc, giving one cycle of latency from an update edge to the output.
REQ-029 Channels SHALL operate independently; a write to one channel SHALL NOT disturb any other channel.

Reset
REQ-030 On rst_n=0 (asynchronous), every channel SHALL reset to acc=0, ovf=0, MODE=RAMP, STEP=0, LOAD=0, PERIOD=0 and square counter=0.
REQ-031 Reset SHALL be released synchronously inside the block via a 2-flop synchroniser, and updates SHALL start on the first edge after release.
REQ-032 Reset asserted mid-burst SHALL abort all state immediately, with no partial write retained.

Configuration
REQ-033 With ADC_PATTERN_LFSR_EN defined, the LFSR mode and its logic SHALL be present.
REQ-034 Without ADC_PATTERN_LFSR_EN, MODE=2 SHALL behave exactly as HOLD and no LFSR logic SHALL be instantiated.

Structure
REQ-035 The MODE encodings, register-select constants and the LFSR tap table indexed by WIDTH SHALL live in the shared package adc_pattern_pkg.
REQ-036 Per-channel state SHALL be implemented in a single sub-module adc_pattern_chan, instantiated NCH times by a generate loop.

Verification
REQ-037 NCH=2, WIDTH=14, SAT=0: ch0 STEP=3, ch1 STEP=-7, both on -> after 4 enabled cycles ch0 reads 12 and ch1 reads 16356.
REQ-038 SAT=0, LOAD=8190, STEP=3 -> next sample is -8191, with ovf high for that single cycle; with SAT=1 the samples are 8191 and ovf stays high.
REQ-039 SQUARE mode, LOAD=100, PERIOD=4 -> output is 100 for 4 enabled cycles, then -100 for 4, repeating.
REQ-040 adc_oe=0 -> adc_data and adc_ovf read Z; re-asserting adc_oe shows the accumulator still advanced while oe was low.
REQ-041 LOAD write and RAMP update in the same cycle -> the loaded value appears; pulsing rst_n low mid-stream -> outputs read 0 immediately.
REQ-042 With ADC_PATTERN_LFSR_EN defined, LFSR mode from LOAD=0 -> nonzero sequence with period 2^14-1; without the macro, MODE=2 holds its value.
